// File: rtl/gray_position_tracker.sv
// Tracks the binary position carried by a qualified Gray-code stream, flags unit steps, wraps and
// illegal jumps, and runs a lock/fault FSM that says when the position can be trusted.
module gray_position_tracker #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned ERR_CNT_W   = 8,
   parameter int unsigned FAULT_LIMIT = 3,
   parameter int unsigned RELOCK_LEN  = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [WIDTH-1:0]     gray_in,
   input  logic                 gray_valid,
   input  logic                 clear,
   output logic [WIDTH-1:0]     bin_pos,
   output logic                 pos_valid,
   output logic                 locked,
   output logic                 dir_up,
   output logic                 dir_dn,
   output logic                 wrap_pulse,
   output logic                 step_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int unsigned BadW = $clog2(FAULT_LIMIT + 1);
   localparam int unsigned RelW = $clog2(RELOCK_LEN + 1);

   typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

   state_e           state;
   logic [WIDTH-1:0] code;
   logic [BadW-1:0]  bad_cnt;
   logic [RelW-1:0]  relock_cnt;

   logic [WIDTH-1:0]     new_bin;
   logic [WIDTH-1:0]     diff;
   logic                 same;
   logic                 one_step;
   logic                 step_up;
   logic                 wrap;
   logic [ERR_CNT_W-1:0] err_next;

   always_comb begin
      new_bin = '0;
      new_bin[WIDTH-1] = gray_in[WIDTH-1];
      for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
         new_bin[i] = new_bin[i+1] ^ gray_in[i];
      end
   end

   // Distance only matters as 0, 1 or more: a single set bit means a legal unit step.
   assign diff     = gray_in ^ code;
   assign same     = (diff == '0);
   assign one_step = !same && ((diff & (diff - WIDTH'(1))) == '0);
   assign step_up  = (new_bin == bin_pos + WIDTH'(1));
   assign wrap     = ((&bin_pos) && (new_bin == '0)) || ((bin_pos == '0) && (&new_bin));
   assign err_next = (&err_cnt) ? err_cnt : err_cnt + ERR_CNT_W'(1);

   assign pos_valid = (state == StTrack);
   assign locked    = (state == StTrack) || (state == StFault);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= StIdle;
         code       <= '0;
         bin_pos    <= '0;
         err_cnt    <= '0;
         bad_cnt    <= '0;
         relock_cnt <= '0;
         dir_up     <= 1'b0;
         dir_dn     <= 1'b0;
         wrap_pulse <= 1'b0;
         step_err   <= 1'b0;
      end else begin
         dir_up     <= 1'b0;
         dir_dn     <= 1'b0;
         wrap_pulse <= 1'b0;
         step_err   <= 1'b0;
         if (clear) begin
            state      <= StIdle;
            code       <= '0;
            bin_pos    <= '0;
            err_cnt    <= '0;
            bad_cnt    <= '0;
            relock_cnt <= '0;
         end else if (gray_valid) begin
            // Every accepted sample resyncs the reference, whatever its distance.
            code    <= gray_in;
            bin_pos <= new_bin;
            unique case (state)
               StIdle: begin
                  state <= StTrack;
               end
               StTrack: begin
                  if (same) begin
                     bad_cnt <= '0;
                  end else if (one_step) begin
                     bad_cnt    <= '0;
                     dir_up     <= step_up;
                     dir_dn     <= !step_up;
                     wrap_pulse <= wrap;
                  end else begin
                     step_err <= 1'b1;
                     err_cnt  <= err_next;
                     bad_cnt  <= bad_cnt + BadW'(1);
                     if (bad_cnt == BadW'(FAULT_LIMIT - 1)) begin
                        state      <= StFault;
                        relock_cnt <= '0;
                     end
                  end
               end
               StFault: begin
                  if (same || one_step) begin
                     if (relock_cnt == RelW'(RELOCK_LEN - 1)) begin
                        state      <= StTrack;
                        bad_cnt    <= '0;
                        relock_cnt <= '0;
                     end else begin
                        relock_cnt <= relock_cnt + RelW'(1);
                     end
                  end else begin
                     step_err   <= 1'b1;
                     err_cnt    <= err_next;
                     relock_cnt <= '0;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule
